// File: rtl/aesha_view_pkg.sv
// Shared types and helpers for the AESHA result viewer.
// Seven-segment encoding is gfedcba, active-low.
package aesha_view_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic logic [6:0] hex_to_7seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aesha_result_viewer_if.sv
// Signal bundle between the AESHA core side and the viewer.
// master drives result/buttons, slave drives the display.
interface aesha_result_viewer_if #(
    parameter int DATA_W     = 512,
    parameter int NUM_DIGITS = 6,
    parameter int IDX_W      = 5
);
    logic [DATA_W-1:0]       data;
    logic                    done;
    logic                    next;
    logic                    prev;
    logic                    auto;
    logic [7*NUM_DIGITS-1:0] segs;
    logic [IDX_W-1:0]        win_idx;
    logic                    captured;

    modport master (
        output data, done, next, prev, auto,
        input  segs, win_idx, captured
    );

    modport slave (
        input  data, done, next, prev, auto,
        output segs, win_idx, captured
    );
endinterface

// File: rtl/aesha_debounce.sv
// Button synchroniser and debouncer with a one-cycle pulse
// on each accepted rising edge.
module aesha_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            sync1  <= i_btn;
            sync2  <= sync1;
            o_rise <= 1'b0;
            if (sync2 != o_level) begin
                if (cnt == LAST) begin
                    o_level <= sync2;
                    o_rise  <= sync2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/aesha_result_viewer.sv
// Captures an AESHA result and pages it onto seven-segment
// digits, stepped by buttons or an auto-scroll timer.
module aesha_result_viewer
    import aesha_view_pkg::*;
#(
    parameter int DATA_W          = 512,
    parameter int NUM_DIGITS      = 6,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SCROLL_CYCLES   = 50000000,
    localparam int WIN_W   = 4 * NUM_DIGITS,
    localparam int NUM_WIN = ceil_div(DATA_W, WIN_W),
    localparam int IDX_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    i_done,
    input  logic                    i_next,
    input  logic                    i_prev,
    input  logic                    i_auto,
    output logic [7*NUM_DIGITS-1:0] o_segs,
    output logic [IDX_W-1:0]        o_win_idx,
    output logic                    o_captured
);
    localparam int PAD_W = NUM_WIN * WIN_W;
    localparam int SC_W  = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
    localparam logic [SC_W-1:0]  TICK_AT = SC_W'(SCROLL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_WIN - 1);

    logic [DATA_W-1:0]       snap;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_n;
    logic [SC_W-1:0]         tcnt;
    logic                    nxt_p;
    logic                    prv_p;
    logic                    nxt_lvl;
    logic                    prv_lvl;
    logic                    manual;
    logic                    tick;
    logic [PAD_W-1:0]        padded;
    logic [WIN_W-1:0]        win;
    logic [7*NUM_DIGITS-1:0] seg_n;

    aesha_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_btn     (i_next),
        .o_level   (nxt_lvl),
        .o_rise    (nxt_p)
    );

    aesha_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_btn     (i_prev),
        .o_level   (prv_lvl),
        .o_rise    (prv_p)
    );

    assign manual = nxt_p | prv_p;
    assign tick   = i_auto && !manual && (tcnt == TICK_AT);

    // Simultaneous next+prev falls through to hold.
    always_comb begin
        idx_n = idx;
        unique case (1'b1)
            (nxt_p && !prv_p) || tick:
                idx_n = (idx == IDX_MAX) ? '0 : idx + 1'b1;
            (prv_p && !nxt_p):
                idx_n = (idx == '0) ? IDX_MAX : idx - 1'b1;
            default: idx_n = idx;
        endcase
    end

    // Bits past DATA_W in the last window read as zero.
    assign padded = PAD_W'(snap);
    assign win    = padded[idx*WIN_W +: WIN_W];

    always_comb begin
        seg_n = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_n[7*k +: 7] = hex_to_7seg(win[4*k +: 4]);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            snap       <= '0;
            o_captured <= 1'b0;
            idx        <= '0;
            tcnt       <= '0;
            o_segs     <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            if (i_done) begin
                snap       <= i_data;
                o_captured <= 1'b1;
            end
            idx    <= idx_n;
            o_segs <= seg_n;
            if (!i_auto || manual || tcnt == TICK_AT) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign o_win_idx = idx;

    logic unused;
    assign unused = nxt_lvl ^ prv_lvl;
endmodule

// File: tb/tb_aesha_result_viewer.sv
// Directed bench for the result viewer with small parameters.
// Expected segment patterns are hand-encoded.
module tb_aesha_result_viewer;
    localparam int DATA_W = 48;
    localparam int ND     = 2;
    localparam int DB     = 4;
    localparam int SC     = 8;
    localparam int IDX_W  = 3;

    logic clk = 1'b0;
    logic rst_n;

    aesha_result_viewer_if #(
        .DATA_W(DATA_W), .NUM_DIGITS(ND), .IDX_W(IDX_W)
    ) vif ();

    aesha_result_viewer #(
        .DATA_W(DATA_W), .NUM_DIGITS(ND),
        .DEBOUNCE_CYCLES(DB), .SCROLL_CYCLES(SC)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_data     (vif.data),
        .i_done     (vif.done),
        .i_next     (vif.next),
        .i_prev     (vif.prev),
        .i_auto     (vif.auto),
        .o_segs     (vif.segs),
        .o_win_idx  (vif.win_idx),
        .o_captured (vif.captured)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [13:0] seg_exp [6];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit is_next);
        if (is_next) vif.next = 1'b1;
        else         vif.prev = 1'b1;
        tick_n(10);
        vif.next = 1'b0;
        vif.prev = 1'b0;
        tick_n(10);
    endtask

    initial begin
        seg_exp[0] = {7'h12, 7'h19};
        seg_exp[1] = {7'h78, 7'h02};
        seg_exp[2] = {7'h10, 7'h00};
        seg_exp[3] = {7'h03, 7'h08};
        seg_exp[4] = {7'h21, 7'h46};
        seg_exp[5] = {7'h0E, 7'h06};

        rst_n    = 1'b0;
        vif.data = '0;
        vif.done = 1'b0;
        vif.next = 1'b0;
        vif.prev = 1'b0;
        vif.auto = 1'b0;
        #12;
        chk("rst_segs", 64'(vif.segs), 64'h3FFF);
        chk("rst_idx", 64'(vif.win_idx), 64'd0);
        chk("rst_cap", 64'(vif.captured), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick_n(1);
        chk("blank_00", 64'(vif.segs), 64'({7'h40, 7'h40}));

        vif.data = 48'hFEDCBA987654;
        vif.done = 1'b1;
        tick_n(1);
        vif.done = 1'b0;
        vif.data = '0;
        chk("cap_flag", 64'(vif.captured), 64'd1);
        tick_n(1);
        chk("cap_segs", 64'(vif.segs), 64'(seg_exp[0]));

        for (int w = 1; w <= 5; w++) begin
            press(1'b1);
            chk("next_idx", 64'(vif.win_idx), 64'(w));
            chk("next_segs", 64'(vif.segs), 64'(seg_exp[w]));
        end
        press(1'b1);
        chk("wrap_idx", 64'(vif.win_idx), 64'd0);
        chk("wrap_segs", 64'(vif.segs), 64'(seg_exp[0]));
        press(1'b0);
        chk("prev_idx", 64'(vif.win_idx), 64'd5);
        chk("prev_segs", 64'(vif.segs), 64'(seg_exp[5]));
        press(1'b1);
        chk("back0_idx", 64'(vif.win_idx), 64'd0);

        for (int i = 0; i < 20; i++) begin
            vif.next = ~vif.next;
            tick_n(2);
        end
        vif.next = 1'b0;
        tick_n(10);
        chk("bounce_idx", 64'(vif.win_idx), 64'd0);

        vif.next = 1'b1;
        vif.prev = 1'b1;
        tick_n(10);
        vif.next = 1'b0;
        vif.prev = 1'b0;
        tick_n(10);
        chk("both_idx", 64'(vif.win_idx), 64'd0);

        vif.auto = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick_n(1);
            if (k == 7)  chk("auto_pre", 64'(vif.win_idx), 64'd0);
            if (k == 47) chk("auto_47", 64'(vif.win_idx), 64'd5);
            if (k % 8 == 0)
                chk("auto_step", 64'(vif.win_idx), 64'((k / 8) % 6));
        end

        vif.auto = 1'b0;
        tick_n(1);
        vif.auto = 1'b1;
        vif.next = 1'b1;
        tick_n(8);
        chk("restart_e7", 64'(vif.win_idx), 64'd1);
        tick_n(6);
        chk("restart_e13", 64'(vif.win_idx), 64'd1);
        tick_n(1);
        chk("restart_e14", 64'(vif.win_idx), 64'd2);

        vif.auto = 1'b0;
        vif.next = 1'b0;
        tick_n(10);
        chk("idle_idx", 64'(vif.win_idx), 64'd2);
        chk("idle_segs", 64'(vif.segs), 64'(seg_exp[2]));

        vif.auto = 1'b1;
        vif.next = 1'b1;
        tick_n(3);
        rst_n = 1'b0;
        #1;
        chk("mrst_idx", 64'(vif.win_idx), 64'd0);
        chk("mrst_cap", 64'(vif.captured), 64'd0);
        chk("mrst_segs", 64'(vif.segs), 64'h3FFF);
        vif.next = 1'b0;
        vif.auto = 1'b0;
        tick_n(2);
        rst_n = 1'b1;
        tick_n(20);
        chk("post_idx", 64'(vif.win_idx), 64'd0);
        chk("post_cap", 64'(vif.captured), 64'd0);
        chk("post_segs", 64'(vif.segs), 64'({7'h40, 7'h40}));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aesha_result_viewer.md
# aesha_result_viewer

Parametrised on-board result viewer for AESHA outputs. It snapshots a wide result word when the core reports done, then shows a selectable NUM_DIGITS-nibble window of it on active-low seven-segment digits. The window is stepped by debounced next/prev buttons or by an auto-scroll timer. It sits between AESHA_top and the board pins, superseding the fixed MSB/LSB switch display.

## Interface
Parameters:
- DATA_W, 512: width of captured result.
- NUM_DIGITS, 6: hex digits shown; window width WIN_W = 4*NUM_DIGITS.
- DEBOUNCE_CYCLES, 50000: stable cycles required to accept a button level (≥1).
- SCROLL_CYCLES, 50000000: cycles per auto-scroll step (≥1).
- Derived: NUM_WIN = ceil(DATA_W/WIN_W) (22 at defaults); IDX_W = max(1, clog2(NUM_WIN)).

Ports:
- i_clk, in, 1: sole clock.
- i_reset_n, in, 1: asynchronous, active-low reset.
- i_data, in, DATA_W: result from core.
- i_done, in, 1: capture strobe (level, sampled each cycle).
- i_next, in, 1: raw button, active-high, asynchronous to i_clk.
- i_prev, in, 1: raw button, active-high, asynchronous to i_clk.
- i_auto, in, 1: auto-scroll enable (static switch; used unsynchronised).
- o_segs, out, 7*NUM_DIGITS: digit k on [7k+6:7k], gfedcba, active-low.
- o_win_idx, out, IDX_W: current window index.
- o_captured, out, 1: high once any capture has occurred since reset.

## Operation
- Snapshot: on every edge with i_done=1, snap <= i_data; o_captured <= 1.
- Window w covers snap bits [w*WIN_W +: WIN_W]; bits at or beyond DATA_W read as 0. With defaults, window 21 shows bits 511:504 on digits 1..0 and zeros on digits 5..2.
- Digit k shows nibble k of the window, using the package hex encoder: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E.
- Each button passes through an aesha_debounce instance:
  - 2-flop synchroniser.
  - Counter: when the synced level differs from the debounced state for DEBOUNCE_CYCLES consecutive cycles, the debounced state flips; any mismatch break clears the counter.
  - One-cycle pulse on a debounced rising edge.
- Index update priority, per cycle:
  1. next and prev pulses together: no change.
  2. next pulse: idx+1, wrapping NUM_WIN-1 → 0.
  3. prev pulse: idx-1, wrapping 0 → NUM_WIN-1.
  4. Auto tick: same as next.
  5. Otherwise hold.
- Auto timer:
  - Counts only while i_auto=1.
  - Reaching SCROLL_CYCLES-1 produces a tick and returns the count to 0.
  - Cleared while i_auto=0 and on any cycle with a manual pulse.
- Capture does not alter the index. Capture and step on the same edge both take effect.

## Timing
- Reset values:
  - snap=0, idx=0, o_win_idx=0, o_captured=0.
  - o_segs all ones (blank); debounced states 0; counters 0.
- Output registers:
  - o_segs is registered and reflects snap/idx as of the previous edge.
  - A capture or step at edge N is visible on o_segs after edge N+1.
  - o_win_idx updates at edge N.
- Button latency: a clean press that is stable from edge 0 produces its pulse, and the idx change, at edge DEBOUNCE_CYCLES+2. o_segs changes one edge later.
- Auto mode: with i_auto held high, idx advances exactly every SCROLL_CYCLES cycles.
- Reset asserted mid-operation clears everything immediately. No press is remembered across reset.

## Structure
- Package aesha_view_pkg holds:
  - hex_to_7seg function (replaces per-digit binto7seg instances).
  - blank constant SEG_OFF = 7'h7F.
  - ceil_div function used for NUM_WIN.
- Sub-module aesha_debounce (parameter DEBOUNCE_CYCLES; ports i_clk, i_reset_n, i_btn, o_level, o_rise), instantiated twice.
- Top-level holds the snapshot, index, auto timer and output registers.

## Test plan
Bench parameters: DATA_W=48, NUM_DIGITS=2, DEBOUNCE_CYCLES=4, SCROLL_CYCLES=8 (NUM_WIN=6).
- Reset, then one clock: o_segs=14'h3FFF during reset, o_win_idx=0, o_captured=0; after the first post-reset edge, o_segs shows "00" = {40,40}.
- i_data=48'hFEDCBA987654 with i_done for one cycle: o_captured=1; two edges later o_segs shows "54" = {12,19}.
- Press next for 10 cycles, 5 times: idx 0→1→2→3→4→5, showing "76","98","BA","DC","FE"; a sixth press wraps to 0 showing "54". One prev from 0 gives idx 5.
- i_next toggled every 2 cycles for 40 cycles: idx unchanged. next and prev asserted together for 10 cycles: idx unchanged.
- i_auto=1 for 48 cycles from idx 0: idx steps every 8 cycles and reaches 0 again after 48. A next pulse mid-interval restarts the 8-cycle count.
- i_reset_n pulled low during a debounce window and auto count: all state returns to reset values immediately. After release, no pending step occurs.
